// File: rtl/eth_tx_scheduler.sv
// rtl/eth_tx_scheduler.sv - round-robin transmit scheduler in front of the RMII frame generator
module eth_tx_scheduler #(
    parameter int NUM_REQ       = 2,
    parameter int GAP_CYCLES    = 48,
    parameter int START_TIMEOUT = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*32-1:0]  req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   ack_err,
    output logic                   gen_start,
    output logic [31:0]            gen_data,
    input  logic                   gen_tx_en,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic [CNT_WIDTH-1:0]   frame_count,
    output logic [CNT_WIDTH-1:0]   err_count
);

    localparam int TMAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, START, ACTIVE, GAP} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic [2:0]             ptr_q, ptr_d;
    logic [2:0]             grant_id_q, grant_id_d;
    logic [31:0]            gen_data_q, gen_data_d;
    logic                   gen_start_q, gen_start_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   ack_err_q, ack_err_d;
    logic [CNT_WIDTH-1:0]   frame_count_q, frame_count_d;
    logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;

    logic                   found;
    logic [2:0]             pick;
    logic [3:0]             idx;
    logic [31:0]            sel_data;
    logic [NUM_REQ-1:0]     grant_onehot;

    // First set request at or above the pointer, wrapping at NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + 4'(k);
            if (idx >= 4'(NUM_REQ)) begin
                idx = idx - 4'(NUM_REQ);
            end
            if (!found && |(req & (NUM_REQ'(1) << idx))) begin
                found = 1'b1;
                pick  = idx[2:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == pick) begin
                sel_data = req_data[32*i +: 32];
            end
        end
    end

    assign grant_onehot = NUM_REQ'(1) << grant_id_q;

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        gen_data_d    = gen_data_q;
        gen_start_d   = gen_start_q;
        ack_d         = '0;
        ack_err_d     = 1'b0;
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;
        case (state_q)
            IDLE: begin
                if (enable && found) begin
                    gen_data_d  = sel_data;
                    grant_id_d  = pick;
                    ptr_d       = (pick == 3'(NUM_REQ - 1)) ? 3'd0 : pick + 3'd1;
                    gen_start_d = 1'b1;
                    tmr_d       = '0;
                    state_d     = START;
                end
            end
            START: begin
                // tx_en wins over a timeout expiring in the same cycle.
                if (gen_tx_en) begin
                    gen_start_d = 1'b0;
                    state_d     = ACTIVE;
                end else if (tmr_q == TW'(START_TIMEOUT - 1)) begin
                    gen_start_d = 1'b0;
                    ack_d       = grant_onehot;
                    ack_err_d   = 1'b1;
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + CNT_WIDTH'(1);
                    end
                    state_d     = IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ACTIVE: begin
                if (!gen_tx_en) begin
                    tmr_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tmr_q == TW'(GAP_CYCLES - 1)) begin
                    ack_d         = grant_onehot;
                    frame_count_d = frame_count_q + CNT_WIDTH'(1);
                    state_d       = IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tmr_q         <= '0;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            gen_data_q    <= '0;
            gen_start_q   <= 1'b0;
            ack_q         <= '0;
            ack_err_q     <= 1'b0;
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            gen_data_q    <= gen_data_d;
            gen_start_q   <= gen_start_d;
            ack_q         <= ack_d;
            ack_err_q     <= ack_err_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign ack         = ack_q;
    assign ack_err     = ack_err_q;
    assign gen_start   = gen_start_q;
    assign gen_data    = gen_data_q;
    assign busy        = (state_q != IDLE);
    assign grant_id    = grant_id_q;
    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;

endmodule
